// File: rtl/shift_window.sv
// Sliding window of the last TAPS accepted samples. Tap 0 is the newest sample.
// ovalid pulses for one cycle after each accepted sample once the window is full.
// Optional macro SHIFT_WINDOW_SUM_EN adds a registered full-precision sum of all taps.
module shift_window #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAPS  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           ivalid,
  input  logic [WIDTH-1:0]               idata,
  input  logic                           flush,
  output logic                           ovalid,
  output logic [WIDTH*TAPS-1:0]          window,
  output logic [$clog2(TAPS+1)-1:0]      fill
`ifdef SHIFT_WINDOW_SUM_EN
  ,
  output logic [WIDTH+$clog2(TAPS)-1:0]  sum
`endif
);

  localparam int unsigned FW = $clog2(TAPS + 1);

  typedef enum logic {StFill, StRun} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] taps_q [TAPS];
  logic [FW-1:0]    fill_q;
  logic             ovalid_q;

  // Window shift, fill counting and FILL/RUN control; outputs are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StFill;
      fill_q   <= '0;
      ovalid_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
    end else if (flush) begin
      // Clear first; a simultaneous sample then lands in tap 0 as the first fill.
      for (int k = 0; k < TAPS; k++) taps_q[k] <= '0;
      state_q  <= StFill;
      ovalid_q <= 1'b0;
      if (ivalid) begin
        taps_q[0] <= idata;
        fill_q    <= FW'(1);
      end else begin
        fill_q    <= '0;
      end
    end else if (ivalid) begin
      taps_q[0] <= idata;
      for (int k = 1; k < TAPS; k++) taps_q[k] <= taps_q[k-1];
      unique case (state_q)
        StFill: begin
          if (fill_q == FW'(TAPS - 1)) begin
            state_q  <= StRun;
            fill_q   <= FW'(TAPS);
            ovalid_q <= 1'b1;
          end else begin
            fill_q   <= fill_q + FW'(1);
            ovalid_q <= 1'b0;
          end
        end
        StRun: begin
          ovalid_q <= 1'b1;
        end
      endcase
    end else begin
      // Gap: taps and fill hold, only the valid pulse drops.
      ovalid_q <= 1'b0;
    end
  end

  // Pack taps into the flat window bus, tap 0 in the least-significant slice.
  always_comb begin
    window = '0;
    for (int k = 0; k < TAPS; k++) window[k*WIDTH +: WIDTH] = taps_q[k];
  end

  assign ovalid = ovalid_q;
  assign fill   = fill_q;

`ifdef SHIFT_WINDOW_SUM_EN
  localparam int unsigned SW = WIDTH + $clog2(TAPS);

  logic [SW-1:0] sum_q;

  // Running sum: add the incoming sample, drop the tap being shifted out (zero while filling).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (flush) begin
      sum_q <= ivalid ? SW'(idata) : '0;
    end else if (ivalid) begin
      sum_q <= sum_q + SW'(idata) - SW'(taps_q[TAPS-1]);
    end
  end

  assign sum = sum_q;
`endif

endmodule

// File: doc/shift_window.md
SHIFT_WINDOW -- requirements
Module: shift_window

Interface
- REQ-001: Parameter WIDTH, default 32; bit width of one sample.
- REQ-002: Parameter TAPS, default 4; window depth in samples, legal range 2..64.
- REQ-003: clock  input  1  sole clock; all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: ivalid  input  1  idata carries a sample this cycle.
- REQ-006: idata  input  WIDTH  input sample.
- REQ-007: flush  input  1  synchronous window clear.
- REQ-008: ovalid  output  1  window holds TAPS fresh samples; registered.
- REQ-009: window  output  WIDTH*TAPS  tap k at bits [(k+1)*WIDTH-1 : k*WIDTH]; tap 0 is the newest sample; registered.
- REQ-010: fill  output  $clog2(TAPS+1)  number of valid taps, 0..TAPS; registered.

Function
- REQ-011: On a cycle with ivalid=1 and flush=0, the block SHALL load tap0 from idata and move tap k-1 into tap k for k=1..TAPS-1; the oldest tap is discarded.
- REQ-012: On a cycle with ivalid=0 and flush=0, all taps and fill SHALL hold.
- REQ-013: The block SHALL have two states: FILL (fill<TAPS) and RUN (fill==TAPS).
- REQ-014: In FILL, each accepted sample SHALL increment fill; the sample that makes fill reach TAPS SHALL move the state to RUN.
- REQ-015: In RUN, fill SHALL saturate at TAPS; accepted samples SHALL NOT change it.
- REQ-016: ovalid SHALL be 1 for exactly one cycle after each edge at which the state is RUN after the update and a sample was accepted; otherwise ovalid SHALL be 0. Latency from the accepted sample to ovalid is 1 clock.
- REQ-017: window and fill SHALL be the values after that update, aligned with ovalid.
- REQ-018: flush=1 with ivalid=0 SHALL zero all taps, set fill=0, set ovalid=0, and enter FILL.
- REQ-019: flush=1 with ivalid=1 SHALL zero all taps, then load idata into tap0, set fill=1, set ovalid=0, and enter FILL. For TAPS>=2 this never reaches RUN.
- REQ-020: When a gap in ivalid occurs in RUN, ovalid SHALL drop and window SHALL hold its last value.

Reset
- REQ-021: reset low SHALL immediately force all taps to 0, fill=0, ovalid=0, and the state to FILL, independent of clock.
- REQ-022: Reset asserted mid-window SHALL discard all partial content; the first sample after release SHALL be counted as fill=1.
- REQ-023: Samples presented while reset is low SHALL be ignored.

Configuration
- REQ-024: Macro SHIFT_WINDOW_SUM_EN, when defined, SHALL add output sum (input-side none) of width WIDTH+$clog2(TAPS), unsigned.
- REQ-025: When SHIFT_WINDOW_SUM_EN is defined, sum SHALL be the full-precision sum of all TAPS taps as they appear in window. It SHALL be registered, aligned with window and ovalid, with no overflow. It SHALL reset to 0 and be cleared by flush, with the REQ-019 load applied.
- REQ-026: Without SHIFT_WINDOW_SUM_EN, the sum port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
- REQ-027: WIDTH=32, TAPS=4; after reset release, drive ivalid=1 continuously with idata=1,2,3,...
  - First ovalid comes the cycle after sample 4.
  - window taps 0..3 = 4,3,2,1; fill=4; sum=10 when SHIFT_WINDOW_SUM_EN is defined.
- REQ-028: Same stream continued. ovalid stays high every cycle; after sample 5 the taps are 5,4,3,2 and sum=14.
- REQ-029: ivalid pattern 1,0,1 in RUN with samples 7 and 8.
  - ovalid pattern 1,0,1.
  - window holds 7,6,5,4 during the gap, then becomes 8,7,6,5.
- REQ-030: flush=1 with ivalid=0 in RUN. The next cycle gives fill=0, ovalid=0, all taps 0; four further samples are needed before ovalid=1.
- REQ-031: flush=1 with ivalid=1 and idata=9 in RUN. The result is fill=1, tap0=9, other taps 0, ovalid=0; three more samples then give ovalid=1.
- REQ-032: Assert reset asynchronously between clock edges with fill=2.
  - Outputs go to 0 before the next edge.
  - After release, samples 1..4 produce ovalid exactly as in REQ-027.
